half_adder: RTL and testbench

//   Bitwise half adder with one registered output stage and a valid/ready handshake.
//   For each bit i: s[i] = a[i] ^ b[i] and c[i] = a[i] & b[i]. No carry propagates between bits.

---
 rtl/half_adder_pkg.sv | 20 ++
 rtl/half_adder_if.sv | 28 ++
 rtl/half_adder_cell.sv | 20 ++
 rtl/half_adder.sv | 61 ++++++
 tb/tb_half_adder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/half_adder_pkg.sv
// Shared constants, per-lane sum/carry helpers and the lane result type for half_adder.
package half_adder_pkg;

    localparam int unsigned HA_MAX_WIDTH = 64;

    // One lane's {sum,carry} result.
    typedef struct packed {
        logic sum;
        logic carry;
    } ha_pair_t;

    function automatic logic ha_sum(input logic a, input logic b);
        return a ^ b;
    endfunction

    function automatic logic ha_carry(input logic a, input logic b);
        return a & b;
    endfunction

endpackage

// File: rtl/half_adder_if.sv
// Handshake bundle for half_adder: operand side (in_valid/in_ready/a/b) and
// result side (out_valid/out_ready/s/c).
//   master : the environment (drives operands, accepts results)
//   slave  : the half_adder stage
interface half_adder_if #(
    parameter int unsigned WIDTH = 1
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, s, c
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, s, c
    );

endinterface

// File: rtl/half_adder_cell.sv
// One combinational half-adder lane.
//   a, b : operand bits
//   s    : a ^ b
//   c    : a & b
module half_adder_cell
    import half_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    ha_pair_t pair;

    assign pair = '{sum: ha_sum(a, b), carry: ha_carry(a, b)};
    assign s    = pair.sum;
    assign c    = pair.carry;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes behind a single registered valid/ready stage.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of half_adder_if (in_valid/in_ready/a/b, out_valid/out_ready/s/c)
// One result per cycle at full throughput; latency one cycle.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    half_adder_if.slave   bus
);

    // Elaboration-time range check on the lane count.
    if (WIDTH < 1 || WIDTH > HA_MAX_WIDTH) begin : g_width_check
        $error("half_adder: WIDTH must be in 1..%0d", HA_MAX_WIDTH);
    end

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] carry_c;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic             out_valid_q;
    logic             accept_c;

    // Independent lanes: no carry crosses lane boundaries.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a (bus.a[i]),
            .b (bus.b[i]),
            .s (sum_c[i]),
            .c (carry_c[i])
        );
    end

    // Ready depends only on the output register and the consumer, never on in_valid.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept_c     = bus.in_valid && bus.in_ready;

    // Output stage: load on accept, clear valid on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= '0;
        end else if (accept_c) begin
            out_valid_q <= 1'b1;
            s_q         <= sum_c;
            c_q         <= carry_c;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.c         = c_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: one 1-lane and one 8-lane instance on a shared clock/reset.
module tb_half_adder;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    half_adder_if #(.WIDTH(1)) if1 ();
    half_adder_if #(.WIDTH(8)) if8 ();

    half_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    half_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        if1.in_valid = 1'b1;
        if1.a        = 1'b1;
        if1.b        = 1'b1;
        if1.out_ready = 1'b1;
        if8.in_valid = 1'b0;
        if8.a        = 8'h00;
        if8.b        = 8'h00;
        if8.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({if1.out_valid, if1.s, if1.c} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold%0d: got v/s/c=%b%b%b expected 000", k, if1.out_valid, if1.s, if1.c);
            end
            checks++;
            if ({if8.out_valid, if8.s, if8.c} !== 17'h0) begin
                errors++;
                $display("FAIL reset_hold8_%0d: got v=%b s=%h c=%h expected 0/00/00", k, if8.out_valid, if8.s, if8.c);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({if1.out_valid, if1.s, if1.c} !== 3'b101) begin
            errors++;
            $display("FAIL reset_first_result: got v/s/c=%b%b%b expected 101", if1.out_valid, if1.s, if1.c);
        end
    endtask

    task automatic test_truth_table();
        logic av, bv;
        if1.in_valid  = 1'b1;
        if1.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            av = 1'((k >> 1) & 1);
            bv = 1'((k >> 2) & 1);
            if1.a = av;
            if1.b = bv;
            step();
            checks++;
            if ({if1.out_valid, if1.s, if1.c} !== {1'b1, av ^ bv, av & bv}) begin
                errors++;
                $display("FAIL truth_ab=%b%b: got v/s/c=%b%b%b expected 1%b%b",
                         av, bv, if1.out_valid, if1.s, if1.c, av ^ bv, av & bv);
            end
        end
        if1.in_valid = 1'b0;
        step();
    endtask

    task automatic test_wide();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] es [3];
        logic [7:0] ec [3];
        va = '{8'hF0, 8'hFF, 8'h00};
        vb = '{8'h3C, 8'hFF, 8'h00};
        es = '{8'hCC, 8'h00, 8'h00};
        ec = '{8'h30, 8'hFF, 8'h00};
        if8.out_ready = 1'b1;
        if8.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if8.a = va[k];
            if8.b = vb[k];
            step();
            checks++;
            if (if8.out_valid !== 1'b1 || if8.s !== es[k] || if8.c !== ec[k]) begin
                errors++;
                $display("FAIL wide_%0d: got v=%b s=%h c=%h expected 1/%h/%h", k, if8.out_valid, if8.s, if8.c, es[k], ec[k]);
            end
        end
        if8.in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        if8.in_valid  = 1'b1;
        if8.out_ready = 1'b1;
        if8.a = 8'h01;
        if8.b = 8'h01;
        step();
        if8.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if8.a = 8'hAA ^ 8'(k);
            if8.b = 8'h55;
            step();
            checks++;
            if (if8.out_valid !== 1'b1 || if8.s !== 8'h00 || if8.c !== 8'h01 || if8.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_%0d: got v=%b s=%h c=%h rdy=%b expected 1/00/01/0",
                         k, if8.out_valid, if8.s, if8.c, if8.in_ready);
            end
        end
        // Release the consumer with garbage on the operand bus: drain only, values kept.
        if8.in_valid  = 1'b0;
        if8.a         = 'x;
        if8.b         = 'x;
        if8.out_ready = 1'b1;
        #1;
        checks++;
        if (if8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got %b expected 1", if8.in_ready);
        end
        step();
        checks++;
        if (if8.out_valid !== 1'b0 || if8.s !== 8'h00 || if8.c !== 8'h01) begin
            errors++;
            $display("FAIL drain_hold: got v=%b s=%h c=%h expected 0/00/01", if8.out_valid, if8.s, if8.c);
        end
        step();
        checks++;
        if (if8.out_valid !== 1'b0 || if8.s !== 8'h00 || if8.c !== 8'h01) begin
            errors++;
            $display("FAIL idle_x_inputs: got v=%b s=%h c=%h expected 0/00/01", if8.out_valid, if8.s, if8.c);
        end
    endtask

    task automatic test_streaming();
        logic [7:0] ra, rb;
        if8.out_ready = 1'b1;
        if8.in_valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if8.a = ra;
            if8.b = rb;
            #1;
            checks++;
            if (if8.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready_%0d: got %b expected 1", k, if8.in_ready);
            end
            step();
            checks++;
            if (if8.out_valid !== 1'b1 || if8.s !== (ra ^ rb) || if8.c !== (ra & rb)) begin
                errors++;
                $display("FAIL stream_%0d: a=%h b=%h got v=%b s=%h c=%h expected 1/%h/%h",
                         k, ra, rb, if8.out_valid, if8.s, if8.c, ra ^ rb, ra & rb);
            end
        end
        if8.in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_hold();
        if8.in_valid  = 1'b1;
        if8.out_ready = 1'b0;
        if8.a = 8'h0F;
        if8.b = 8'h0F;
        step();
        checks++;
        if (if8.out_valid !== 1'b1 || if8.c !== 8'h0F) begin
            errors++;
            $display("FAIL midhold_load: got v=%b c=%h expected 1/0f", if8.out_valid, if8.c);
        end
        if8.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        checks++;
        if (if8.out_valid !== 1'b0 || if8.s !== 8'h00 || if8.c !== 8'h00) begin
            errors++;
            $display("FAIL midhold_reset: got v=%b s=%h c=%h expected 0/00/00", if8.out_valid, if8.s, if8.c);
        end
        rst_n = 1'b1;
        if8.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (if8.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midhold_no_deliver_%0d: got v=%b expected 0", k, if8.out_valid);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_truth_table();
        test_wide();
        test_backpressure();
        test_streaming();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
